// File: rtl/isqrt_iter.sv
// ---------------------------------------------------------------------------
// isqrt_iter -- iterative unsigned integer square root.
//
// This module computes a square root by the restoring digit-by-digit method.
// It resolves one root bit per clock cycle, starting with the MSB. Input and
// output each use a valid/ready handshake, and only one operation is in
// flight at a time.
//
// Parameters
//   IN_W        radicand width (even, 4..64)
//   OUT_W       root width, fixed to IN_W/2 (localparam)
//   ZERO_FLOOR  root reported for x=0 when ISQRT_ZERO_FLOOR_EN is defined
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   in_valid   radicand offered
//   in_ready   block idle, can accept a radicand
//   in_data    unsigned radicand x
//   out_valid  result available
//   out_ready  consumer accepts result
//   out_root   floor(sqrt(x))
//   out_rem    x - root^2 (0..2*root)
//
// Build option
//   ISQRT_ZERO_FLOOR_EN  when defined, a root of 0 is reported as
//                        ZERO_FLOOR[OUT_W-1:0] (remainder stays 0)
// ---------------------------------------------------------------------------
module isqrt_iter #(
    parameter  int IN_W       = 32,
    localparam int OUT_W      = IN_W / 2,
    parameter  int ZERO_FLOOR = 256
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_root,
    output logic [OUT_W:0]   out_rem
);

    localparam int CNT_W = $clog2(OUT_W + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(OUT_W);

`ifdef ISQRT_ZERO_FLOOR_EN
    localparam logic ZF_EN = 1'b1;
`else
    localparam logic ZF_EN = 1'b0;
`endif
    // With the feature off, this is zero, so substituting it for a zero
    // root has no effect.
    localparam logic [OUT_W-1:0] ZERO_ROOT = ZF_EN ? OUT_W'(ZERO_FLOOR) : '0;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [IN_W-1:0]  rad_q;
    logic [OUT_W-1:0] root_q;
    logic [OUT_W:0]   rem_q;
    logic [CNT_W-1:0] cnt_q;
    logic [OUT_W-1:0] out_root_q;
    logic [OUT_W:0]   out_rem_q;

    // One restoring step. The partial remainder is at most 2*root_partial, so
    // bringing down the next two radicand bits needs OUT_W+2 bits. The
    // result always fits back into OUT_W+1 bits.
    logic [OUT_W+1:0] trial;
    logic [OUT_W+1:0] test_val;
    logic [OUT_W:0]   diff;
    logic             fits;

    always_comb begin
        trial    = {rem_q[OUT_W-1:0], rad_q[IN_W-1 -: 2]};
        test_val = {root_q, 2'b01};
        diff     = (OUT_W+1)'(trial - test_val);
        fits     = (trial >= test_val);
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and handshake outputs
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = CALC;
                end
            end
            CALC: begin
                if (cnt_q == LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // CALC runs OUT_W bit steps (cnt 0..OUT_W-1). It then spends one final
    // cycle (cnt == OUT_W) loading the output registers. So out_valid rises
    // OUT_W+1 edges after the accepting edge. The outputs then stay frozen
    // through DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rad_q      <= '0;
            root_q     <= '0;
            rem_q      <= '0;
            cnt_q      <= '0;
            out_root_q <= '0;
            out_rem_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        rad_q  <= in_data;
                        root_q <= '0;
                        rem_q  <= '0;
                        cnt_q  <= '0;
                    end
                end
                CALC: begin
                    if (cnt_q != LAST) begin
                        rad_q  <= rad_q << 2;
                        root_q <= {root_q[OUT_W-2:0], fits};
                        rem_q  <= fits ? diff : trial[OUT_W:0];
                        cnt_q  <= cnt_q + CNT_W'(1);
                    end else begin
                        out_root_q <= (root_q == '0) ? ZERO_ROOT : root_q;
                        out_rem_q  <= rem_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_root = out_root_q;
    assign out_rem  = out_rem_q;

endmodule

// File: tb/tb_isqrt_iter.sv
// ---------------------------------------------------------------------------
// tb_isqrt_iter -- self-checking bench for isqrt_iter.
//
// Instance u_a uses IN_W=32 and instance u_b uses IN_W=16. The bench applies
// directed vectors with hand-computed roots, backpressure, a mid-CALC reset,
// and a random sweep checked against a binary-search reference root.
// ---------------------------------------------------------------------------
module tb_isqrt_iter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [31:0] a_in_data;
    logic [15:0] a_root;
    logic [16:0] a_rem;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [15:0] b_in_data;
    logic [7:0]  b_root;
    logic [8:0]  b_rem;

`ifdef ISQRT_ZERO_FLOOR_EN
    localparam logic [15:0] A_ZERO = 16'h0100;
`else
    localparam logic [15:0] A_ZERO = 16'h0000;
`endif
    // 256 truncated to 8 bits is 0, so the 16-bit instance reports 0 either way.
    localparam logic [7:0] B_ZERO = 8'h00;

    isqrt_iter #(.IN_W(32)) u_a (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_data   (a_in_data),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_root  (a_root),
        .out_rem   (a_rem)
    );

    isqrt_iter #(.IN_W(16)) u_b (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_data   (b_in_data),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_root  (b_root),
        .out_rem   (b_rem)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_root(input logic [63:0] x);
        logic [63:0] lo, hi, mid;
        lo = 0;
        hi = 64'h1_0000;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            if (mid * mid <= x) lo = mid;
            else                hi = mid;
        end
        return lo;
    endfunction

    // Hold > 0 keeps out_ready low for that many cycles after out_valid.
    // in_valid also stays high while busy, to show that it is ignored.
    task automatic run_a(input string tag, input logic [31:0] x, input logic [15:0] er,
                         input logic [16:0] em, input int hold);
        int n;
        n = 0;
        while (!a_in_ready && n < 50) begin @(posedge clk); #1; n++; end
        check({tag, " in_ready"}, a_in_ready, 1);
        a_in_data  = x;
        a_in_valid = 1'b1;
        @(posedge clk); #1;
        a_in_valid = (hold > 0);
        a_in_data  = ~x;
        check({tag, " busy"}, a_in_ready, 0);
        n = 0;
        while (!a_out_valid && n < 40) begin @(posedge clk); #1; n++; end
        check({tag, " latency"}, n, 17);
        check({tag, " root"}, a_root, er);
        check({tag, " rem"}, a_rem, em);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, " hold"}, {a_out_valid, a_in_ready, a_root, a_rem}, {1'b1, 1'b0, er, em});
        end
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        @(posedge clk); #1;
        a_out_ready = 1'b0;
        check({tag, " release"}, {a_out_valid, a_in_ready}, 2'b01);
    endtask

    task automatic run_b(input string tag, input logic [15:0] x, input logic [7:0] er,
                         input logic [8:0] em);
        int n;
        n = 0;
        while (!b_in_ready && n < 50) begin @(posedge clk); #1; n++; end
        check({tag, " in_ready"}, b_in_ready, 1);
        b_in_data  = x;
        b_in_valid = 1'b1;
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        b_in_data  = ~x;
        check({tag, " busy"}, b_in_ready, 0);
        n = 0;
        while (!b_out_valid && n < 40) begin @(posedge clk); #1; n++; end
        check({tag, " latency"}, n, 9);
        check({tag, " root"}, b_root, er);
        check({tag, " rem"}, b_rem, em);
        b_out_ready = 1'b1;
        @(posedge clk); #1;
        b_out_ready = 1'b0;
        check({tag, " release"}, {b_out_valid, b_in_ready}, 2'b01);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] x, r;
        int          n;

        reset       = 1'b1;
        a_in_valid  = 1'b0; a_in_data = '0; a_out_ready = 1'b0;
        b_in_valid  = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset a", {a_in_ready, a_out_valid, a_root, a_rem}, {1'b1, 1'b0, 16'h0, 17'h0});
        check("reset b", {b_in_ready, b_out_valid, b_root, b_rem}, {1'b1, 1'b0, 8'h0, 9'h0});
        @(negedge clk);
        reset = 1'b0;

        run_a("x1e6", 32'd1000000, 16'd1000, 17'd0, 0);
        run_a("x99", 32'd99, 16'd9, 17'd18, 0);
        run_a("xmax", 32'hFFFF_FFFF, 16'hFFFF, 17'h1FFFE, 0);
        run_a("x0", 32'd0, A_ZERO, 17'd0, 0);
        run_a("bp144", 32'd144, 16'd12, 17'd0, 10);

        // Reset five cycles into CALC must clear everything at once.
        a_in_data  = 32'd50;
        a_in_valid = 1'b1;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("abort clear", {a_in_ready, a_out_valid, a_root, a_rem}, {1'b1, 1'b0, 16'h0, 17'h0});
        a_in_data  = 32'd50;
        a_in_valid = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        check("accept after reset", a_in_ready, 0);
        a_in_valid = 1'b0;
        n = 0;
        while (!a_out_valid && n < 40) begin @(posedge clk); #1; n++; end
        check("x50 latency", n, 17);
        check("x50 root", a_root, 7);
        check("x50 rem", a_rem, 1);
        a_out_ready = 1'b1;
        @(posedge clk); #1;
        a_out_ready = 1'b0;
        check("x50 release", {a_out_valid, a_in_ready}, 2'b01);

        run_b("b65535", 16'd65535, 8'd255, 9'd510);
        run_b("b0", 16'd0, B_ZERO, 9'd0);
        run_b("b99", 16'd99, 8'd9, 9'd18);

        for (int i = 0; i < 1000; i++) begin
            x = 64'($urandom);
            r = ref_root(x);
            run_a("rand32", x[31:0], (r == 0) ? A_ZERO : r[15:0], 17'(x - r * r), 0);
        end
        for (int i = 0; i < 1000; i++) begin
            x = 64'($urandom_range(0, 65535));
            r = ref_root(x);
            run_b("rand16", x[15:0], (r == 0) ? B_ZERO : r[7:0], 9'(x - r * r));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
